// File: rtl/pid_pkg.sv
// Shared definitions for the multi-channel PID controller: FSM state
// encodings, register-map offsets and the saturation helpers.
package pid_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ERR   = 3'd1;
    localparam state_t ST_MUL_P = 3'd2;
    localparam state_t ST_MUL_I = 3'd3;
    localparam state_t ST_MUL_D = 3'd4;
    localparam state_t ST_OUT   = 3'd5;
    localparam state_t ST_DONE  = 3'd6;

    localparam int REG_KP      = 0;
    localparam int REG_KI      = 1;
    localparam int REG_KD      = 2;
    localparam int REG_LIMIT   = 3;
    localparam int REGS_PER_CH = 4;

    // Clamp to the full two's-complement range of a w-bit signed value.
    function automatic logic signed [63:0] sat_d(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi)      return hi;
        else if (x < lo) return lo;
        else             return x;
    endfunction

    // Symmetric clamp for the integrator so wind-up cannot reach the asymmetric minimum.
    function automatic logic signed [63:0] sat_acc(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        if (x > hi)       return hi;
        else if (x < -hi) return -hi;
        else              return x;
    endfunction

endpackage

// File: rtl/pid_mac.sv
// Shared signed multiply-accumulate for all channels. The accumulator is
// wide enough that three gain*term products never overflow; the output is
// the Q-scaled sum clamped symmetrically to the channel limit.
module pid_mac #(
    parameter int D_WIDTH = 16,
    parameter int Q_BITS  = 13,
    parameter int ACC_W   = 20
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      clr,
    input  logic                      acc_en,
    input  logic signed [D_WIDTH-1:0] a,
    input  logic signed [ACC_W-1:0]   b,
    input  logic [D_WIDTH-2:0]        limit,
    output logic signed [D_WIDTH-1:0] result
);
    import pid_pkg::*;

    localparam int AW = D_WIDTH + ACC_W + 2;

    logic signed [D_WIDTH+ACC_W-1:0] prod;
    logic signed [AW-1:0]            acc;
    logic signed [AW-1:0]            shifted;
    logic signed [AW-1:0]            lim_w;

    assign prod = a * b;

    // Load the first product of a channel, then accumulate the rest.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)       acc <= '0;
        else if (clr)    acc <= AW'(prod);
        else if (acc_en) acc <= acc + AW'(prod);
    end

    // Floor-shift out the fractional bits and clamp to +/-limit.
    always_comb begin
        shifted = acc >>> Q_BITS;
        lim_w   = AW'(signed'({1'b0, limit}));
        result  = D_WIDTH'(shifted);
        if (shifted > lim_w)       result = D_WIDTH'(lim_w);
        else if (shifted < -lim_w) result = D_WIDTH'(-lim_w);
    end

endmodule

// File: rtl/pid_mc.sv
// Multi-channel PID controller. One FSM walks the channels in turn through
// a shared MAC; results collect in a shadow array and are published to
// out together on a single out_valid pulse.
module pid_mc #(
    parameter int D_WIDTH = 16,
    parameter int Q_BITS  = 13,
    parameter int N_CH    = 4,
    parameter int GUARD   = 4
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      write_enable,
    input  logic                      iterate_enable,
    input  logic [D_WIDTH-1:0]        reg_addr,
    input  logic [D_WIDTH-1:0]        reg_data,
    input  logic [N_CH*D_WIDTH-1:0]   target,
    input  logic [N_CH*D_WIDTH-1:0]   measurement,
    output logic [N_CH*D_WIDTH-1:0]   out,
    output logic                      out_valid,
    output logic                      busy
);
    import pid_pkg::*;

    localparam int ACC_W = D_WIDTH + GUARD;
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_t                    state;
    logic [CH_W-1:0]           ch;
    logic [N_CH*D_WIDTH-1:0]   tgt_q;
    logic [N_CH*D_WIDTH-1:0]   meas_q;

    logic signed [D_WIDTH-1:0] kp     [N_CH];
    logic signed [D_WIDTH-1:0] ki     [N_CH];
    logic signed [D_WIDTH-1:0] kd     [N_CH];
    logic [D_WIDTH-2:0]        limit  [N_CH];
    logic signed [ACC_W-1:0]   integ  [N_CH];
    logic signed [D_WIDTH-1:0] e_prev [N_CH];
    logic signed [D_WIDTH-1:0] shadow [N_CH];

    logic signed [D_WIDTH-1:0] e_r, d_r;
    logic signed [ACC_W-1:0]   i_r;
    logic signed [D_WIDTH-1:0] tgt_c, meas_c, e_sat, d_sat;
    logic signed [ACC_W-1:0]   i_sat;

    logic                      mac_clr, mac_en;
    logic signed [D_WIDTH-1:0] mac_a;
    logic signed [ACC_W-1:0]   mac_b;
    logic signed [D_WIDTH-1:0] mac_result;

    logic                      wr_ok;
    logic [CH_W-1:0]           wa_ch;

    // Writes land only while fully idle so an iteration sees one gain set.
    assign wr_ok = !write_enable && !busy && (state == ST_IDLE)
                   && (reg_addr < D_WIDTH'(REGS_PER_CH * N_CH));
    assign wa_ch = reg_addr[2 +: CH_W];

    // Register file: gains and clamp limits.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int c = 0; c < N_CH; c++) begin
                kp[c]    <= '0;
                ki[c]    <= '0;
                kd[c]    <= '0;
                limit[c] <= '1;
            end
        end else if (wr_ok) begin
            case (reg_addr[1:0])
                2'(REG_KP):    kp[wa_ch]    <= reg_data;
                2'(REG_KI):    ki[wa_ch]    <= reg_data;
                2'(REG_KD):    kd[wa_ch]    <= reg_data;
                2'(REG_LIMIT): limit[wa_ch] <= reg_data[D_WIDTH-2:0];
                default: ;
            endcase
        end
    end

    // Error, integrator and derivative terms for the current channel.
    always_comb begin
        tgt_c  = tgt_q[ch*D_WIDTH +: D_WIDTH];
        meas_c = meas_q[ch*D_WIDTH +: D_WIDTH];
        e_sat  = D_WIDTH'(sat_d(64'(tgt_c) - 64'(meas_c), D_WIDTH));
        i_sat  = ACC_W'(sat_acc(64'(integ[ch]) + 64'(e_sat), ACC_W));
        d_sat  = D_WIDTH'(sat_d(64'(e_sat) - 64'(e_prev[ch]), D_WIDTH));
    end

    // Route the gain/term pair for the current multiply step into the MAC.
    always_comb begin
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        mac_a   = '0;
        mac_b   = '0;
        case (state)
            ST_MUL_P: begin mac_clr = 1'b1; mac_a = kp[ch]; mac_b = ACC_W'(e_r); end
            ST_MUL_I: begin mac_en  = 1'b1; mac_a = ki[ch]; mac_b = i_r;         end
            ST_MUL_D: begin mac_en  = 1'b1; mac_a = kd[ch]; mac_b = ACC_W'(d_r); end
            default: ;
        endcase
    end

    pid_mac #(.D_WIDTH(D_WIDTH), .Q_BITS(Q_BITS), .ACC_W(ACC_W)) u_mac (
        .clk    (clk),
        .rstb   (rstb),
        .clr    (mac_clr),
        .acc_en (mac_en),
        .a      (mac_a),
        .b      (mac_b),
        .limit  (limit[ch]),
        .result (mac_result)
    );

    // Sequencer: per channel ERR -> MUL_P -> MUL_I -> MUL_D -> OUT, then DONE.
    // busy trails the FSM by one cycle so it covers the out_valid cycle.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= ST_IDLE;
            ch        <= '0;
            tgt_q     <= '0;
            meas_q    <= '0;
            e_r       <= '0;
            d_r       <= '0;
            i_r       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                integ[c]  <= '0;
                e_prev[c] <= '0;
                shadow[c] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            busy      <= (state != ST_IDLE);
            case (state)
                ST_IDLE: if (iterate_enable) begin
                    tgt_q  <= target;
                    meas_q <= measurement;
                    ch     <= '0;
                    state  <= ST_ERR;
                end
                ST_ERR: begin
                    e_r   <= e_sat;
                    i_r   <= i_sat;
                    d_r   <= d_sat;
                    state <= ST_MUL_P;
                end
                ST_MUL_P: state <= ST_MUL_I;
                ST_MUL_I: state <= ST_MUL_D;
                ST_MUL_D: state <= ST_OUT;
                ST_OUT: begin
                    shadow[ch] <= mac_result;
                    integ[ch]  <= i_r;
                    e_prev[ch] <= e_r;
                    if (ch == CH_W'(N_CH - 1)) begin
                        state <= ST_DONE;
                    end else begin
                        ch    <= ch + 1'b1;
                        state <= ST_ERR;
                    end
                end
                ST_DONE: begin
                    for (int c = 0; c < N_CH; c++) out[c*D_WIDTH +: D_WIDTH] <= shadow[c];
                    out_valid <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pid_mc.sv
// Directed bench for pid_mc with 16-bit data, Q13 gains, 4 channels.
module tb_pid_mc;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        write_enable = 1'b1;
    logic        iterate_enable = 1'b0;
    logic [15:0] reg_addr = '0;
    logic [15:0] reg_data = '0;
    logic [63:0] target = '0;
    logic [63:0] measurement = '0;
    logic [63:0] out;
    logic        out_valid;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pid_mc #(.D_WIDTH(16), .Q_BITS(13), .N_CH(4), .GUARD(4)) dut (
        .clk            (clk),
        .rstb           (rstb),
        .write_enable   (write_enable),
        .iterate_enable (iterate_enable),
        .reg_addr       (reg_addr),
        .reg_data       (reg_data),
        .target         (target),
        .measurement    (measurement),
        .out            (out),
        .out_valid      (out_valid),
        .busy           (busy)
    );

    function automatic logic [15:0] outc(input int c);
        return out[c*16 +: 16];
    endfunction

    task automatic do_reset;
        @(negedge clk);
        rstb = 1'b0; iterate_enable = 1'b0; write_enable = 1'b1;
        target = '0; measurement = '0;
        @(negedge clk);
        rstb = 1'b1;
    endtask

    task automatic wr(input int a, input int d);
        @(negedge clk);
        write_enable = 1'b0; reg_addr = 16'(a); reg_data = 16'(d);
        @(negedge clk);
        write_enable = 1'b1;
    endtask

    task automatic set_ch(input int c, input int t, input int m);
        target[c*16 +: 16]      = 16'(t);
        measurement[c*16 +: 16] = 16'(m);
    endtask

    task automatic run_iter(output int lat, output int bcnt);
        lat = 0; bcnt = 0;
        @(negedge clk); iterate_enable = 1'b1;
        @(posedge clk); #1 iterate_enable = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (busy) bcnt++;
            if (out_valid) begin lat = n; break; end
        end
        n_tests++;
        if (lat == 0) begin n_fail++; $display("FAIL iter_timeout: out_valid not seen in 60 cycles"); end
    endtask

    task automatic test_reset;
        int lat, b;
        do_reset;
        #1;
        n_tests++; if (out !== 64'd0) begin n_fail++; $display("FAIL reset_out: got %h want 0", out); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        wr(0, 16384); set_ch(0, 20000, 0);
        run_iter(lat, b);
        n_tests++; if (outc(0) !== 16'd32767) begin n_fail++; $display("FAIL reset_limit: got %0d want 32767", $signed(outc(0))); end
    endtask

    task automatic test_p_only;
        int lat, b;
        do_reset;
        wr(0, 8192); set_ch(0, 1000, 0);
        run_iter(lat, b);
        n_tests++; if (lat != 21) begin n_fail++; $display("FAIL p_latency: got %0d want 21", lat); end
        n_tests++; if (b != 21) begin n_fail++; $display("FAIL p_busy_cycles: got %0d want 21", b); end
        n_tests++; if (outc(0) !== 16'd1000) begin n_fail++; $display("FAIL p_out0: got %0d want 1000", $signed(outc(0))); end
        n_tests++; if (out[63:16] !== 48'd0) begin n_fail++; $display("FAIL p_out123: got %h want 0", out[63:16]); end
        @(posedge clk); #1;
        n_tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL p_after: busy %b valid %b want 0 0", busy, out_valid); end
    endtask

    task automatic test_i_only;
        int lat, b;
        do_reset;
        wr(5, 4096); set_ch(1, 100, 0);
        for (int k = 1; k <= 3; k++) begin
            run_iter(lat, b);
            n_tests++; if (outc(1) !== 16'(50 * k)) begin n_fail++; $display("FAIL i_out1_%0d: got %0d want %0d", k, $signed(outc(1)), 50 * k); end
        end
    endtask

    task automatic test_d_only;
        int lat, b;
        int tv[3] = '{0, 500, 500};
        int ev[3] = '{0, 500, 0};
        do_reset;
        wr(10, 8192);
        for (int k = 0; k < 3; k++) begin
            set_ch(2, tv[k], 0);
            run_iter(lat, b);
            n_tests++; if (outc(2) !== 16'(ev[k])) begin n_fail++; $display("FAIL d_out2_%0d: got %0d want %0d", k, $signed(outc(2)), ev[k]); end
        end
    endtask

    task automatic test_clamp;
        int lat, b;
        do_reset;
        wr(12, 16384);
        wr(15, 16'h87D0);
        set_ch(3, 5000, 0);
        run_iter(lat, b);
        n_tests++; if (outc(3) !== 16'd2000) begin n_fail++; $display("FAIL clamp_pos: got %0d want 2000", $signed(outc(3))); end
        set_ch(3, 0, 5000);
        run_iter(lat, b);
        n_tests++; if (outc(3) !== 16'(-2000)) begin n_fail++; $display("FAIL clamp_neg: got %0d want -2000", $signed(outc(3))); end
    endtask

    task automatic test_antiwindup;
        int lat, b;
        do_reset;
        wr(1, 8192); set_ch(0, 32767, -32768);
        for (int k = 0; k < 16; k++) run_iter(lat, b);
        n_tests++; if (outc(0) !== 16'd32767) begin n_fail++; $display("FAIL aw_wind16: got %0d want 32767", $signed(outc(0))); end
        set_ch(0, -32768, 0);
        for (int k = 1; k <= 16; k++) begin
            run_iter(lat, b);
            if (k == 15) begin
                n_tests++; if (outc(0) !== 16'd32752) begin n_fail++; $display("FAIL aw16_unwind15: got %0d want 32752", $signed(outc(0))); end
            end
        end
        n_tests++; if (outc(0) !== 16'(-16)) begin n_fail++; $display("FAIL aw16_unwind16: got %0d want -16", $signed(outc(0))); end
        do_reset;
        wr(1, 8192); set_ch(0, 32767, -32768);
        for (int k = 0; k < 20; k++) run_iter(lat, b);
        n_tests++; if (outc(0) !== 16'd32767) begin n_fail++; $display("FAIL aw_wind20: got %0d want 32767", $signed(outc(0))); end
        set_ch(0, -32768, 0);
        for (int k = 1; k <= 16; k++) begin
            run_iter(lat, b);
            if (k == 15) begin
                n_tests++; if (outc(0) !== 16'd32767) begin n_fail++; $display("FAIL aw20_unwind15: got %0d want 32767", $signed(outc(0))); end
            end
        end
        n_tests++; if (outc(0) !== 16'(-1)) begin n_fail++; $display("FAIL aw20_unwind16: got %0d want -1", $signed(outc(0))); end
    endtask

    task automatic test_blocking;
        int lat, b, extra;
        do_reset;
        wr(0, 8192); set_ch(0, 1000, 0);
        @(negedge clk); iterate_enable = 1'b1;
        @(posedge clk); #1 iterate_enable = 1'b0;
        lat = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = n; break; end
            if (n == 5) begin write_enable = 1'b0; reg_addr = 16'd0; reg_data = 16'd16384; iterate_enable = 1'b1; end
            if (n == 6) begin write_enable = 1'b1; iterate_enable = 1'b0; end
        end
        n_tests++; if (lat != 21) begin n_fail++; $display("FAIL blk_latency: got %0d want 21", lat); end
        n_tests++; if (outc(0) !== 16'd1000) begin n_fail++; $display("FAIL blk_out0: got %0d want 1000", $signed(outc(0))); end
        extra = 0;
        for (int n = 0; n < 40; n++) begin @(posedge clk); #1; if (out_valid) extra++; end
        n_tests++; if (extra != 0) begin n_fail++; $display("FAIL blk_extra_valid: got %0d want 0", extra); end
        wr(16, 16384);
        run_iter(lat, b);
        n_tests++; if (outc(0) !== 16'd1000) begin n_fail++; $display("FAIL blk_gain_kept: got %0d want 1000", $signed(outc(0))); end
    endtask

    task automatic test_back_to_back;
        int first, second;
        do_reset;
        wr(0, 8192); set_ch(0, 700, 0);
        @(negedge clk); iterate_enable = 1'b1;
        @(posedge clk); #1;
        first = 0; second = 0;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                if (first == 0) first = n;
                else begin second = n; break; end
            end
        end
        iterate_enable = 1'b0;
        n_tests++; if (first != 21 || second != 43) begin n_fail++; $display("FAIL b2b_timing: got %0d,%0d want 21,43", first, second); end
        n_tests++; if (outc(0) !== 16'd700) begin n_fail++; $display("FAIL b2b_out0: got %0d want 700", $signed(outc(0))); end
        repeat (30) @(posedge clk);
    endtask

    task automatic test_reset_mid;
        int lat, b, seen;
        do_reset;
        wr(0, 8192); set_ch(0, 1000, 0);
        run_iter(lat, b);
        n_tests++; if (outc(0) !== 16'd1000) begin n_fail++; $display("FAIL rm_pre: got %0d want 1000", $signed(outc(0))); end
        @(negedge clk); iterate_enable = 1'b1;
        @(posedge clk); #1 iterate_enable = 1'b0;
        repeat (10) @(posedge clk);
        #1 rstb = 1'b0;
        #1;
        n_tests++; if (out !== 64'd0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rm_abort: out %h busy %b valid %b want 0 0 0", out, busy, out_valid);
        end
        @(negedge clk); rstb = 1'b1;
        seen = 0;
        for (int n = 0; n < 30; n++) begin @(posedge clk); #1; if (out_valid) seen++; end
        n_tests++; if (seen != 0) begin n_fail++; $display("FAIL rm_no_valid: got %0d want 0", seen); end
        run_iter(lat, b);
        n_tests++; if (outc(0) !== 16'd0) begin n_fail++; $display("FAIL rm_gain_cleared: got %0d want 0", $signed(outc(0))); end
    endtask

    initial begin
        test_reset;
        test_p_only;
        test_i_only;
        test_d_only;
        test_clamp;
        test_antiwindup;
        test_blocking;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
